// File: rtl/iob_eth_pkg.sv
// Shared Ethernet constants: CRC-32 parameters, FCS engine state encoding
// and the byte-wide CRC update used by the FCS engine.
package iob_eth_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FCS   = 2'd2
  } state_t;

  // Non-reflected register fed LSB-first: eight serial steps, fully unrolled.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = {c[30:0], 1'b0} ^ ((c[31] ^ data[i]) ? CRC32_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/iob_reverse.sv
// Bit-order reversal: data_o[i] = data_i[DATA_W-1-i].
module iob_reverse #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    assign data_o[i] = data_i[DATA_W-1-i];
  end

endmodule

// File: rtl/iob_eth_crc32_fcs.sv
// Byte-serial Ethernet CRC-32: appends the FCS in TX mode, checks the
// residue in RX mode.
module iob_eth_crc32_fcs
  import iob_eth_pkg::*;
(
  input  logic        clk_i,
  input  logic        cke_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        gen_fcs_i,
  input  logic        data_valid_i,
  input  logic [7:0]  data_i,
  input  logic        last_i,
  output logic        fcs_valid_o,
  input  logic        fcs_ready_i,
  output logic [7:0]  fcs_data_o,
  output logic [31:0] crc_o,
  output logic        crc_ok_o,
  output logic        busy_o,
  output logic        done_o,
  output state_t      state_o
);

  // FCS handshake: a byte transfers on every rising edge where fcs_valid_o
  // and fcs_ready_i are both high; fcs_data_o holds until that transfer.

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_next, crc_rev, fcs_word;
  logic [1:0]  cnt_q;
  logic        gen_q, done_q, crc_ok_q;
  logic        mode, in_frame, byte_fire, last_fire, fcs_hs, fcs_end, rx_end;

  iob_reverse #(.DATA_W(32)) u_reverse (
    .data_i (crc_q),
    .data_o (crc_rev)
  );

  assign fcs_word = ~crc_rev;

  // start_i overrides everything: it behaves as if the frame were in ACCUM
  // with an INIT seed, which also covers start+data+last single-byte frames.
  always_comb begin
    mode      = start_i ? gen_fcs_i : gen_q;
    in_frame  = start_i || (state_q == ACCUM);
    byte_fire = in_frame && data_valid_i;
    last_fire = byte_fire && last_i;
    fcs_hs    = (state_q == FCS) && !start_i && fcs_ready_i;
    fcs_end   = fcs_hs && (cnt_q == 2'd3);
    rx_end    = last_fire && !mode;
    crc_next  = crc32_byte(start_i ? CRC32_INIT : crc_q, data_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else if (cke_i) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (in_frame) begin
      state_d = last_fire ? (mode ? FCS : IDLE) : ACCUM;
    end else if (fcs_end) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    fcs_valid_o = (state_q == FCS);
    busy_o      = (state_q != IDLE);
    state_o     = state_q;
    fcs_data_o  = 8'h00;
    if (fcs_valid_o) begin
      case (cnt_q)
        2'd0:    fcs_data_o = fcs_word[7:0];
        2'd1:    fcs_data_o = fcs_word[15:8];
        2'd2:    fcs_data_o = fcs_word[23:16];
        default: fcs_data_o = fcs_word[31:24];
      endcase
    end
  end

  // crc_q is untouched in FCS so crc_o keeps showing the frame CRC.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crc_q    <= CRC32_INIT;
      cnt_q    <= 2'd0;
      gen_q    <= 1'b0;
      done_q   <= 1'b0;
      crc_ok_q <= 1'b0;
    end else if (cke_i) begin
      if (byte_fire) begin
        crc_q <= crc_next;
      end else if (start_i) begin
        crc_q <= CRC32_INIT;
      end
      if (start_i || last_fire) begin
        cnt_q <= 2'd0;
      end else if (fcs_hs) begin
        cnt_q <= cnt_q + 2'd1;
      end
      if (start_i) begin
        gen_q <= gen_fcs_i;
      end
      done_q <= rx_end || fcs_end;
      if (rx_end) begin
        crc_ok_q <= (crc_next == CRC32_RESIDUE);
      end else if (start_i) begin
        crc_ok_q <= 1'b0;
      end
    end
  end

  assign crc_o    = crc_q;
  assign crc_ok_o = crc_ok_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_iob_eth_crc32_fcs.sv
// Directed bench for iob_eth_crc32_fcs: table of frames with known CRC-32
// values plus hand-written abort, backpressure, clock-enable and reset cases.
module tb_iob_eth_crc32_fcs;
  import iob_eth_pkg::*;

  logic        clk = 1'b0;
  logic        cke, rst, start, gen_fcs, data_valid, last, fcs_ready;
  logic [7:0]  data;
  logic        fcs_valid, crc_ok, busy, done;
  logic [7:0]  fcs_data;
  logic [31:0] crc;
  state_t      state;

  int checks = 0;
  int errors = 0;
  logic [31:0] m;

  typedef struct {
    logic        gen;
    int          len;
    logic [127:0] b;
    logic [31:0] fcs;
    logic        ok;
  } vec_t;

  vec_t tbl [7];

  always #5 clk = ~clk;

  iob_eth_crc32_fcs dut (
    .clk_i        (clk),
    .cke_i        (cke),
    .rst_i        (rst),
    .start_i      (start),
    .gen_fcs_i    (gen_fcs),
    .data_valid_i (data_valid),
    .data_i       (data),
    .last_i       (last),
    .fcs_valid_o  (fcs_valid),
    .fcs_ready_i  (fcs_ready),
    .fcs_data_o   (fcs_data),
    .crc_o        (crc),
    .crc_ok_o     (crc_ok),
    .busy_o       (busy),
    .done_o       (done),
    .state_o      (state)
  );

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  // Reflected (right-shifting) CRC-32 reference; its bit-reverse is crc_o.
  function automatic logic [31:0] ref_upd(input logic [31:0] r, input logic [7:0] b);
    logic [31:0] x;
    x = r ^ {24'h0, b};
    for (int i = 0; i < 8; i++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic st, input logic gen, input logic [7:0] d, input logic lst);
    start = st; gen_fcs = gen; data_valid = 1'b1; data = d; last = lst;
    if (st) m = 32'hFFFFFFFF;
    m = ref_upd(m, d);
    tick();
    start = 1'b0; gen_fcs = 1'b0; data_valid = 1'b0; data = 8'h00; last = 1'b0;
    check("crc_after_byte", crc, rev32(m));
  endtask

  task automatic send_bytes(input vec_t v);
    for (int i = 0; i < v.len; i++) begin
      drive_byte(i == 0, v.gen, v.b[127-8*i -: 8], i == v.len - 1);
      if (i < v.len - 1) begin
        check("accum_busy", {31'h0, busy}, 32'd1);
        check("accum_no_done", {31'h0, done}, 32'd0);
        check("accum_no_fcs_valid", {31'h0, fcs_valid}, 32'd0);
        if (i == 0) check("ok_cleared_on_start", {31'h0, crc_ok}, 32'd0);
      end
    end
  endtask

  task automatic collect_fcs(input bit rnd, input logic [31:0] exp_fcs);
    logic [31:0] got;
    logic [7:0]  prev;
    int          hs, cyc;
    bit          held;
    got = 32'h0; prev = 8'h00; hs = 0; cyc = 0; held = 1'b0;
    check("fcs_valid_rise", {31'h0, fcs_valid}, 32'd1);
    while (hs < 4 && cyc < 200) begin
      fcs_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held) check("fcs_data_stable", {24'h0, fcs_data}, {24'h0, prev});
      check("fcs_no_early_done", {31'h0, done}, 32'd0);
      check("fcs_crc_held", crc, rev32(m));
      if (fcs_valid && fcs_ready) begin
        got[8*hs +: 8] = fcs_data;
        hs++;
      end
      prev = fcs_data;
      held = fcs_valid && !fcs_ready;
      tick();
      cyc++;
    end
    fcs_ready = 1'b0;
    check("fcs_handshakes", hs, 4);
    if (!rnd) check("fcs_cycles", cyc, 4);
    check("fcs_value", got, exp_fcs);
    check("tx_done", {31'h0, done}, 32'd1);
    check("tx_busy_drop", {31'h0, busy}, 32'd0);
    check("tx_valid_drop", {31'h0, fcs_valid}, 32'd0);
    check("tx_data_idle", {24'h0, fcs_data}, 32'd0);
    check("tx_ok_zero", {31'h0, crc_ok}, 32'd0);
    tick();
    check("tx_done_pulse", {31'h0, done}, 32'd0);
  endtask

  task automatic finish_rx(input logic exp_ok);
    check("rx_done", {31'h0, done}, 32'd1);
    check("rx_ok", {31'h0, crc_ok}, {31'h0, exp_ok});
    check("rx_busy_drop", {31'h0, busy}, 32'd0);
    check("rx_no_fcs_valid", {31'h0, fcs_valid}, 32'd0);
    if (exp_ok) check("rx_residue", crc, CRC32_RESIDUE);
  endtask

  task automatic check_reset_outputs();
    check("rst_fcs_valid", {31'h0, fcs_valid}, 32'd0);
    check("rst_fcs_data", {24'h0, fcs_data}, 32'd0);
    check("rst_crc", crc, 32'hFFFFFFFF);
    check("rst_crc_ok", {31'h0, crc_ok}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 9,  {72'h313233343536373839, 56'h0}, 32'hCBF43926, 1'b0};
    tbl[1] = '{1'b1, 1,  {8'h00, 120'h0}, 32'hD202EF8D, 1'b0};
    tbl[2] = '{1'b1, 1,  {8'hFF, 120'h0}, 32'hFF000000, 1'b0};
    tbl[3] = '{1'b1, 3,  {24'h616263, 104'h0}, 32'h352441C2, 1'b0};
    tbl[4] = '{1'b0, 13, {104'h3132333435363738392639F4CB, 24'h0}, 32'h0, 1'b1};
    tbl[5] = '{1'b0, 13, {104'h3132333435363738392639F4CA, 24'h0}, 32'h0, 1'b0};
    tbl[6] = '{1'b0, 5,  {40'h6143BEB7E8, 88'h0}, 32'h0, 1'b1};

    cke = 1'b1; rst = 1'b1; start = 1'b0; gen_fcs = 1'b0; data_valid = 1'b0;
    data = 8'h00; last = 1'b0; fcs_ready = 1'b0; m = 32'hFFFFFFFF;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_outputs();
    tick();
    check_reset_outputs();

    for (int k = 0; k < 7; k++) begin
      send_bytes(tbl[k]);
      if (tbl[k].gen) begin
        collect_fcs(1'b0, tbl[k].fcs);
      end else begin
        finish_rx(tbl[k].ok);
        tick();
        check("rx_done_pulse", {31'h0, done}, 32'd0);
        check("rx_ok_hold", {31'h0, crc_ok}, {31'h0, tbl[k].ok});
      end
      tick();
    end

    // Abort during ACCUM, then a full frame.
    for (int i = 0; i < 4; i++) drive_byte(i == 0, 1'b1, tbl[0].b[127-8*i -: 8], 1'b0);
    send_bytes(tbl[0]);
    collect_fcs(1'b0, 32'hCBF43926);

    // Abort during FCS with ready low, then a full frame.
    send_bytes(tbl[3]);
    fcs_ready = 1'b0;
    tick();
    check("abort_fcs_waiting", {31'h0, fcs_valid}, 32'd1);
    send_bytes(tbl[0]);
    collect_fcs(1'b0, 32'hCBF43926);

    // Random backpressure.
    send_bytes(tbl[0]);
    collect_fcs(1'b1, 32'hCBF43926);

    // Clock-enable gap mid-ACCUM with junk on the inputs.
    for (int i = 0; i < 4; i++) drive_byte(i == 0, 1'b1, tbl[0].b[127-8*i -: 8], 1'b0);
    cke = 1'b0;
    for (int j = 0; j < 3; j++) begin
      data_valid = 1'b1; data = 8'h55; last = 1'b1;
      tick();
      check("cke_crc_frozen", crc, rev32(m));
      check("cke_busy_frozen", {31'h0, busy}, 32'd1);
    end
    data_valid = 1'b0; last = 1'b0; cke = 1'b1;
    for (int i = 4; i < 9; i++) drive_byte(1'b0, 1'b0, tbl[0].b[127-8*i -: 8], i == 8);
    collect_fcs(1'b0, 32'hCBF43926);

    // done_o held, not re-pulsed, while cke is low.
    send_bytes(tbl[6]);
    finish_rx(1'b1);
    cke = 1'b0;
    tick();
    check("cke_done_held", {31'h0, done}, 32'd1);
    tick();
    check("cke_done_held2", {31'h0, done}, 32'd1);
    cke = 1'b1;
    tick();
    check("cke_done_release", {31'h0, done}, 32'd0);

    // Reset in the middle of FCS after one handshake.
    send_bytes(tbl[3]);
    fcs_ready = 1'b1;
    tick();
    fcs_ready = 1'b0;
    check("pre_rst_fcs_busy", {31'h0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs();
    tick();
    check_reset_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual running required finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/iob_eth_crc32_fcs.md
# iob_eth_crc32_fcs

Byte-serial Ethernet CRC-32 engine for the MAC datapath. It accumulates the IEEE 802.3 CRC over frame bytes in transmission order (LSB first). In TX mode it appends the 4-byte FCS through a valid/ready output; in RX mode it checks the received FCS against the CRC-32 residue. It sits between the MAC byte stream and the bit-order fix-up, and it consumes a 32-bit bit reversal to form the FCS.

## Interface
- POLY, 32'h04C11DB7, CRC-32 generator polynomial (non-reflected form).
- INIT, 32'hFFFFFFFF, CRC register seed at frame start.
- RESIDUE, 32'hC704DD7B, register value after a frame plus its correct FCS has been processed.
- clk_i  input  1  clock; all state changes on the rising edge.
- cke_i  input  1  clock enable; when low, all state is frozen.
- rst_i  input  1  reset, synchronous, active-high.
- start_i  input  1  begin a frame: seeds CRC with INIT and samples gen_fcs_i.
- gen_fcs_i  input  1  1 = TX (append FCS), 0 = RX (check residue).
- data_valid_i  input  1  data_i carries a frame byte this cycle; there is no backpressure.
- data_i  input  8  frame byte; bit 0 is first on the wire.
- last_i  input  1  qualifies the final frame byte. In RX mode this byte is the last FCS byte.
- fcs_valid_o  output  1  an FCS byte is available.
- fcs_ready_i  input  1  downstream accepts the FCS byte.
- fcs_data_o  output  8  FCS byte.
- crc_o  output  32  live CRC register value.
- crc_ok_o  output  1  RX result: crc == RESIDUE. Valid from done_o until the next start_i.
- busy_o  output  1  state is not IDLE.
- done_o  output  1  one-cycle pulse when the frame completes.

## Operation
- States: IDLE, ACCUM, FCS.
- Per-byte update, for i = 0..7: fb = crc[31] ^ data_i[i]; crc = {crc[30:0],1'b0} ^ (fb ? POLY : 0).
- FCS = ~bitreverse32(crc). FCS bytes are emitted in the order FCS[7:0], [15:8], [23:16], [31:24].
- IDLE → ACCUM on start_i.
- If start_i and data_valid_i are high in the same cycle, that byte is processed with INIT as the seed.
- If last_i is also high in that cycle, the frame is a single byte.
- ACCUM: each data_valid_i updates crc. On data_valid_i && last_i:
  - TX mode → FCS, with byte counter cleared to 0.
  - RX mode → IDLE, with done_o pulsed and crc_ok_o set to (next crc == RESIDUE).
- FCS: fcs_valid_o = 1. fcs_data_o = FCS byte selected by a 2-bit counter.
  - The counter advances on fcs_valid_o && fcs_ready_i.
  - The handshake on byte 3 → IDLE with a done_o pulse.
  - crc is held during FCS. crc_o therefore still shows the frame CRC.
- Inputs ignored:
  - data_valid_i in IDLE and FCS;
  - last_i without data_valid_i;
  - gen_fcs_i except when start_i is high.
- start_i in ACCUM or FCS aborts the current frame and restarts in ACCUM with crc = INIT. It takes priority over all other events. No done_o pulse is generated for the aborted frame.
- crc_ok_o is cleared on start_i. It stays 0 after TX frames.

## Timing
- Reset values: state IDLE, crc INIT, counter 0. fcs_valid_o, fcs_data_o (8'h00 in IDLE), crc_ok_o, busy_o and done_o are all 0.
- rst_i mid-frame drops the frame immediately. The cycle after reset, all outputs hold their reset values.
- crc_o reflects a byte one cycle after that byte's data_valid_i.
- fcs_valid_o rises the cycle after the last byte and stays high until byte 3 handshakes.
- fcs_data_o is stable while fcs_ready_i is low.
- Throughput: 1 byte/cycle in ACCUM. In FCS, minimum 4 cycles with ready held high.
- done_o: RX, the cycle after the last byte; TX, the cycle after the byte-3 handshake.
- crc_ok_o updates together with done_o.
- cke_i low freezes state, counter and outputs. done_o is held high, not re-pulsed.

## Structure
- Shared package iob_eth_pkg holds:
  - CRC32_POLY, CRC32_INIT, CRC32_RESIDUE constants;
  - the state encoding (IDLE=2'd0, ACCUM=2'd1, FCS=2'd2).
- The byte update is a combinational function: 8 unrolled bit steps.
- One sub-module: iob_reverse with DATA_W=32 on crc; the output is inverted to form the FCS.

## Test plan
- TX "123456789" (0x31..0x39), ready always high → FCS bytes 0x26, 0x39, 0xF4, 0xCB on 4 consecutive cycles; done_o one cycle later.
- RX the same 9 bytes followed by 26 39 F4 CB with last_i on 0xCB → crc_o = 32'hC704DD7B, crc_ok_o = 1 with done_o. Repeat with 0xCA as the final byte → crc_ok_o = 0.
- Single byte 0x00 with start_i, data_valid_i and last_i all high in one cycle, TX mode → FCS bytes 8D EF 02 D2.
- Backpressure: toggle fcs_ready_i pseudo-randomly during FCS → fcs_data_o stable while ready is low; exactly 4 handshakes; busy_o drops with done_o.
- start_i during ACCUM and during FCS → no done_o for the aborted frame; the restarted frame "123456789" still yields 0xCBF43926.
- rst_i asserted mid-FCS and cke_i held low for 3 cycles mid-ACCUM:
  - after the reset, all outputs are at reset values the next cycle;
  - the cke_i gap leaves the final CRC unchanged.
